// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: instruction decode into ALU
// control, operands, immediate and control bits, plus load-use hazard detection.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            stall,
    input  logic            flush,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [4:0]      ex_alu_control,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_illegal
);

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR  = 5'd3,
        ALU_XOR  = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
        ALU_SLT  = 5'd8, ALU_SLTU = 5'd9
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic            valid;
        alu_op_e         alu;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            illegal;
    } ex_reg_t;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, shamt;
    logic       uses_rs1, uses_rs2;
    ex_reg_t    dec;
    ex_reg_t    ex_d, ex_q;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign funct7 = id_instr[31:25];

    assign imm_i = XLEN'($signed(id_instr[31:20]));
    assign imm_s = XLEN'($signed({id_instr[31:25], id_instr[11:7]}));
    assign imm_b = XLEN'($signed({id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({id_instr[31:12], 12'b0}));
    assign shamt = XLEN'(id_instr[24:20]);

    always_comb begin
        dec          = '0;
        dec.valid    = id_valid;
        dec.alu      = ALU_ADD;
        dec.op_a     = rs1_data;
        dec.op_b     = rs2_data;
        dec.rs2_data = rs2_data;
        dec.pc       = id_pc;
        dec.rd       = rd;
        dec.funct3   = funct3;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        unique case (opcode)
            OP_R: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.reg_write = 1'b1;
                unique case (funct3)
                    3'b000:  dec.alu = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu = ALU_SLL;
                    3'b010:  dec.alu = ALU_SLT;
                    3'b011:  dec.alu = ALU_SLTU;
                    3'b100:  dec.alu = ALU_XOR;
                    3'b101:  dec.alu = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
                dec.illegal = !((funct7 == 7'b0000000) ||
                                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_IMM: begin
                uses_rs1      = 1'b1;
                dec.reg_write = 1'b1;
                dec.op_b      = imm_i;
                dec.imm       = imm_i;
                unique case (funct3)
                    3'b000:  dec.alu = ALU_ADD;
                    3'b001: begin
                        dec.alu     = ALU_SLL;
                        dec.op_b    = shamt;
                        dec.illegal = (funct7 != 7'b0000000);
                    end
                    3'b010:  dec.alu = ALU_SLT;
                    3'b011:  dec.alu = ALU_SLTU;
                    3'b100:  dec.alu = ALU_XOR;
                    3'b101: begin
                        dec.alu     = id_instr[30] ? ALU_SRA : ALU_SRL;
                        dec.op_b    = shamt;
                        dec.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    3'b110:  dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                uses_rs1      = 1'b1;
                dec.op_b      = imm_i;
                dec.imm       = imm_i;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_STORE: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.op_b      = imm_s;
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                dec.alu    = ALU_SUB;
                dec.imm    = imm_b;
                dec.branch = 1'b1;
            end
            OP_LUI: begin
                dec.op_a      = '0;
                dec.op_b      = imm_u;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec.op_a      = id_pc;
                dec.op_b      = imm_u;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // An illegal instruction must not touch architectural state downstream.
        if (dec.illegal) begin
            dec.alu       = ALU_ADD;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
        end
        if (rd == 5'd0) dec.reg_write = 1'b0;
        if (!id_valid) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.illegal   = 1'b0;
        end
    end

    assign hazard_stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                          ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

    // Flush beats stall; a load-use bubble has the same contents as a flush.
    always_comb begin
        ex_d = ex_q;
        if (flush)             ex_d = '0;
        else if (stall)        ex_d = ex_q;
        else if (hazard_stall) ex_d = '0;
        else                   ex_d = dec;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ex_valid       = ex_q.valid;
    assign ex_alu_control = ex_q.alu;
    assign ex_op_a        = ex_q.op_a;
    assign ex_op_b        = ex_q.op_b;
    assign ex_rs2_data    = ex_q.rs2_data;
    assign ex_imm         = ex_q.imm;
    assign ex_pc          = ex_q.pc;
    assign ex_rd          = ex_q.rd;
    assign ex_funct3      = ex_q.funct3;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_branch      = ex_q.branch;
    assign ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage using hand-encoded RV32I words.
module tb_id_ex_stage;

    logic        clk, rst_n;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, rs1_data, rs2_data;
    logic        stall, flush;
    logic        hazard_stall, ex_valid;
    logic [4:0]  ex_alu_control, ex_rd;
    logic [31:0] ex_op_a, ex_op_b, ex_rs2_data, ex_imm, ex_pc;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        id_valid = 1'b1;
        id_instr = instr;
        id_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc = '0;
        rs1_data = '0; rs2_data = '0; stall = 1'b0; flush = 1'b0;
        #2;
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_op_a", ex_op_a, 0);
        check("rst_reg_write", 32'(ex_reg_write), 0);
        check("rst_hazard", 32'(hazard_stall), 0);
        #10;
        rst_n = 1'b1;

        // add x3,x1,x2
        drive(32'h002081B3, 32'h0000_0010, 32'd5, 32'd7);
        tick();
        check("add_valid", 32'(ex_valid), 1);
        check("add_alu", 32'(ex_alu_control), 0);
        check("add_op_a", ex_op_a, 5);
        check("add_op_b", ex_op_b, 7);
        check("add_rd", 32'(ex_rd), 3);
        check("add_reg_write", 32'(ex_reg_write), 1);
        check("add_pc", ex_pc, 32'h10);

        drive(32'h402081B3, 32'h0000_0014, 32'd5, 32'd7);
        tick();
        check("sub_alu", 32'(ex_alu_control), 1);

        // addi x5,x0,-1
        drive(32'hFFF00293, 32'h0000_0018, 32'd0, 32'd9);
        tick();
        check("addi_op_b", ex_op_b, 32'hFFFF_FFFF);
        check("addi_imm", ex_imm, 32'hFFFF_FFFF);
        check("addi_rd", 32'(ex_rd), 5);
        check("addi_alu", 32'(ex_alu_control), 0);

        // lw x6,0(x1)
        drive(32'h0000A303, 32'h0000_001C, 32'h100, 32'd0);
        #1;
        check("lw_no_hazard", 32'(hazard_stall), 0);
        tick();
        check("lw_mem_read", 32'(ex_mem_read), 1);
        check("lw_rd", 32'(ex_rd), 6);
        check("lw_funct3", 32'(ex_funct3), 2);

        // add x7,x6,x2 depends on the load
        drive(32'h002303B3, 32'h0000_0020, 32'd1, 32'd2);
        #1;
        check("lu_hazard", 32'(hazard_stall), 1);
        tick();
        check("bubble_valid", 32'(ex_valid), 0);
        check("bubble_mem_read", 32'(ex_mem_read), 0);
        check("bubble_reg_write", 32'(ex_reg_write), 0);
        check("replay_hazard", 32'(hazard_stall), 0);
        tick();
        check("replay_valid", 32'(ex_valid), 1);
        check("replay_rd", 32'(ex_rd), 7);
        check("replay_pc", ex_pc, 32'h20);

        // lui x1,0x12345 with non-zero rs1_data that must not reach op_a
        drive(32'h123450B7, 32'h0000_0040, 32'hDEAD_BEEF, 32'd3);
        tick();
        check("lui_op_a", ex_op_a, 0);
        check("lui_op_b", ex_op_b, 32'h1234_5000);
        check("lui_reg_write", 32'(ex_reg_write), 1);

        // auipc x2,1
        drive(32'h00001117, 32'h0000_0040, 32'hDEAD_BEEF, 32'd3);
        tick();
        check("auipc_op_a", ex_op_a, 32'h40);
        check("auipc_op_b", ex_op_b, 32'h1000);

        // addi x0,x0,1: rd==0 kills reg_write
        drive(32'h00100013, 32'h0000_0044, 32'd0, 32'd0);
        tick();
        check("rd0_valid", 32'(ex_valid), 1);
        check("rd0_reg_write", 32'(ex_reg_write), 0);

        // srai x5,x1,3
        drive(32'h4030D293, 32'h0000_0048, 32'h8000_0000, 32'd0);
        tick();
        check("srai_alu", 32'(ex_alu_control), 7);
        check("srai_op_b", ex_op_b, 3);
        check("srai_illegal", 32'(ex_illegal), 0);

        // funct7=0100000 with funct3=001 is not a legal R-type
        drive(32'h402091B3, 32'h0000_004C, 32'd1, 32'd2);
        tick();
        check("badr_illegal", 32'(ex_illegal), 1);
        check("badr_reg_write", 32'(ex_reg_write), 0);

        // beq x1,x2,-4
        drive(32'hFE208EE3, 32'h0000_0050, 32'd4, 32'd4);
        tick();
        check("beq_alu", 32'(ex_alu_control), 1);
        check("beq_branch", 32'(ex_branch), 1);
        check("beq_imm", ex_imm, 32'hFFFF_FFFC);
        check("beq_reg_write", 32'(ex_reg_write), 0);

        // sw x2,8(x1)
        drive(32'h0020A423, 32'h0000_0054, 32'h200, 32'hCAFE_0001);
        tick();
        check("sw_mem_write", 32'(ex_mem_write), 1);
        check("sw_op_b", ex_op_b, 8);
        check("sw_rs2_data", ex_rs2_data, 32'hCAFE_0001);
        check("sw_reg_write", 32'(ex_reg_write), 0);

        // Hold for three cycles with changing ID inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h002081B3 + 32'(i << 7), 32'h100 + 32'(i), 32'(i), 32'(i + 1));
            tick();
            check("stall_valid", 32'(ex_valid), 1);
            check("stall_mem_write", 32'(ex_mem_write), 1);
            check("stall_op_b", ex_op_b, 8);
            check("stall_pc", ex_pc, 32'h54);
        end
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_mem_write", 32'(ex_mem_write), 0);
        stall = 1'b0;
        flush = 1'b0;

        // Unknown opcode, then async reset in the middle of the cycle
        drive(32'h0000007F, 32'h0000_0060, 32'd1, 32'd2);
        tick();
        check("ill_illegal", 32'(ex_illegal), 1);
        check("ill_reg_write", 32'(ex_reg_write), 0);
        check("ill_alu", 32'(ex_alu_control), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid), 0);
        check("arst_illegal", 32'(ex_illegal), 0);
        check("arst_pc", ex_pc, 0);
        check("arst_op_a", ex_op_a, 0);
        tick();
        check("arst_hold_valid", 32'(ex_valid), 0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
